maxpool_window_ctrl: RTL and testbench
======================================

// Module: maxpool_window_ctrl
// PURPOSE
//   Sequences a raster pixel stream from the conv stage into non-overlapping 2x2 windows for the maxpool stage.
//   Buffers one even row in an internal line buffer, then pairs it with the following odd row.
//   Emits one window plus a one-cycle maxpool_en_maxfifo strobe per stride-2 position.
//   Drives the registered maxfifo->maxpool pipeline stage directly; that stage cannot stall, so output is strobe-only.
// PARAMETERS
//   DATA_WIDTH   16  pixel width, two's-complement signed
//   KERNEL_SIZE  2   window edge and stride; only 2 is supported, elaboration error otherwise
//   IMG_WIDTH    64  pixels per input row, >=2; also the line buffer depth
//   IMG_HEIGHT   64  rows per frame, >=2
// PORTS
//   clk                 in   1              rising-edge clock
//   rst                 in   1              synchronous, active-high reset
//   start               in   1              begin a frame; sampled only in IDLE
//   pixel_in            in   DATA_WIDTH     input pixel, raster order
//   pixel_valid         in   1              pixel_in valid
//   pixel_ready         out  1              ctrl accepts pixel; transfer = valid & ready
//   maxpool_en_maxfifo  out  1              1-cycle strobe: window_maxfifo valid
//   window_maxfifo      out  DATA_WIDTH [KERNEL_SIZE][KERNEL_SIZE]   [row][col] window
//   out_row             out  $clog2(IMG_HEIGHT/2)  pooled row index of current window
//   out_col             out  $clog2(IMG_WIDTH/2)   pooled col index of current window
//   busy                out  1              high from start accept until frame_done
//   frame_done          out  1              1-cycle pulse after the last input pixel is accepted
// BEHAVIOUR
//   Reset: FSM=IDLE; pixel_ready, maxpool_en_maxfifo, busy, frame_done=0; window_maxfifo, out_row, out_col=0.
//     Counters are cleared. Line buffer contents are not cleared (don't care).
//   FSM states: IDLE, ROW_EVEN, ROW_ODD, DONE.
//     IDLE -> ROW_EVEN on start. While busy, start is ignored.
//     ROW_EVEN: each transfer writes linebuf[col]. On the last col, go to ROW_ODD, or to DONE if it was the last row.
//     ROW_ODD: each transfer reads linebuf[col] and holds the previous odd-row pixel in a register.
//       On the last col, go to DONE if it was the last row, else to ROW_EVEN.
//     DONE: frame_done=1 for one cycle, busy drops, then -> IDLE.
//   pixel_ready = 1 in ROW_EVEN/ROW_ODD, 0 in IDLE/DONE. No bubbles: one pixel per cycle is sustained.
//   Window emit: on a transfer in ROW_ODD at odd col c, the next cycle drives:
//     [0][0]=linebuf[c-1], [0][1]=linebuf[c], [1][0]=held pixel c-1, [1][1]=pixel_in.
//     maxpool_en_maxfifo=1 for that single cycle. Latency 1 clk from the accepting edge.
//   Outputs: out_row=row>>1 and out_col=c>>1, registered alongside the window.
//     window_maxfifo holds its value between strobes.
//   Odd IMG_WIDTH: last col of each row is accepted but never windowed.
//   Odd IMG_HEIGHT: last row is accepted into linebuf only; no windows are produced from it.
//   Stalls: pixel_valid=0 freezes col/row counters and the held register. There is no timeout.
//   Counters: col wraps IMG_WIDTH-1 -> 0 with row+1. Row stops at IMG_HEIGHT-1 (-> DONE); it never wraps.
//   Reset mid-frame returns to IDLE next edge. Any in-flight strobe is squashed; no frame_done is issued.
//   Data values are passed through unmodified (no arithmetic) unless the macro below is defined.
// CONFIGURATION
//   MAXPOOL_CTRL_RELU_EN defined: every accepted pixel is clamped, with pixel_in<0 replaced by 0.
//     The clamp applies to both the linebuf write and the direct window path. Latency is unchanged.
//   Not defined: signed values pass through unchanged. No extra logic is inferred.
// TESTING
//   T1: IMG 4x4, pixels 0..15, valid always high.
//     -> 4 strobes: {0,1,4,5}@(0,0), {2,3,6,7}@(0,1), {8,9,12,13}@(1,0), {10,11,14,15}@(1,1).
//     -> frame_done 1 clk after pixel 15 is accepted.
//   T2: same frame with pixel_valid toggled 1,0,1,0...
//     -> identical windows and order; each strobe 1 clk after its accepting edge; never 2 strobes back-to-back.
//   T3: IMG 5x5, pixels 0..24.
//     -> exactly 4 strobes, first {0,1,5,6}, last {12,13,17,18}; col 4 and row 4 never appear; frame_done asserts.
//   T4: rst asserted after pixel 9 of a 4x4 frame.
//     -> next cycle: IDLE, pixel_ready=0, no further strobe, no frame_done.
//     -> restart with pixels 100..115: first window {100,101,104,105}.
//   T5: start pulsed again mid-frame -> ignored; window sequence matches T1.
//   T6 (RELU_EN): pixels -8,3,-1,7 at 2x2 -> window {0,3,0,7}.
//     T6 without RELU_EN: window {-8,3,-1,7}.

Source files
------------

// File: rtl/maxpool_window_ctrl.sv
// Sequences a raster pixel stream into non-overlapping 2x2 stride-2 windows for the maxpool stage.
// Optional macro MAXPOOL_CTRL_RELU_EN clamps negative accepted pixels to zero.
module maxpool_window_ctrl #(
   parameter  int DATA_WIDTH  = 16,
   parameter  int KERNEL_SIZE = 2,
   parameter  int IMG_WIDTH   = 64,
   parameter  int IMG_HEIGHT  = 64,
   localparam int OUT_ROW_W   = (IMG_HEIGHT >= 4) ? $clog2(IMG_HEIGHT / 2) : 1,
   localparam int OUT_COL_W   = (IMG_WIDTH >= 4) ? $clog2(IMG_WIDTH / 2) : 1
) (
   input  logic                                                    clk,
   input  logic                                                    rst,
   input  logic                                                    start,
   input  logic [DATA_WIDTH-1:0]                                   pixel_in,
   input  logic                                                    pixel_valid,
   output logic                                                    pixel_ready,
   output logic                                                    maxpool_en_maxfifo,
   output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0] window_maxfifo,
   output logic [OUT_ROW_W-1:0]                                    out_row,
   output logic [OUT_COL_W-1:0]                                    out_col,
   output logic                                                    busy,
   output logic                                                    frame_done
);

   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam int ROW_W = $clog2(IMG_HEIGHT);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

   if (KERNEL_SIZE != 2) begin : g_bad_kernel
      $error("maxpool_window_ctrl: only KERNEL_SIZE=2 is supported");
   end
   if (IMG_WIDTH < 2 || IMG_HEIGHT < 2) begin : g_bad_image
      $error("maxpool_window_ctrl: IMG_WIDTH and IMG_HEIGHT must be >= 2");
   end

   typedef enum logic [1:0] {
      IDLE,
      ROW_EVEN,
      ROW_ODD,
      DONE
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [COL_W-1:0]      col;
   logic [ROW_W-1:0]      row;
   logic [DATA_WIDTH-1:0] linebuf [IMG_WIDTH];
   logic [DATA_WIDTH-1:0] held;
   logic [DATA_WIDTH-1:0] pixel_d;
   logic                  transfer;
   logic                  last_col;
   logic                  last_row;
   logic                  emit;

`ifdef MAXPOOL_CTRL_RELU_EN
   assign pixel_d = pixel_in[DATA_WIDTH-1] ? '0 : pixel_in;
`else
   assign pixel_d = pixel_in;
`endif

   assign transfer = pixel_valid & pixel_ready;
   assign last_col = (col == LAST_COL);
   assign last_row = (row == LAST_ROW);
   // A window completes on the odd-row pixel at an odd column.
   assign emit     = transfer && (state == ROW_ODD) && col[0];

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      state_nxt   = state;
      pixel_ready = 1'b0;
      busy        = 1'b0;
      frame_done  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_nxt = ROW_EVEN;
         end
         ROW_EVEN: begin
            pixel_ready = 1'b1;
            busy        = 1'b1;
            if (pixel_valid && last_col) state_nxt = last_row ? DONE : ROW_ODD;
         end
         ROW_ODD: begin
            pixel_ready = 1'b1;
            busy        = 1'b1;
            if (pixel_valid && last_col) state_nxt = last_row ? DONE : ROW_EVEN;
         end
         DONE: begin
            frame_done = 1'b1;
            state_nxt  = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || state == IDLE) begin
         col <= '0;
         row <= '0;
      end else if (transfer) begin
         if (last_col) begin
            col <= '0;
            if (!last_row) row <= row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // NOTE: the line buffer and held pixel carry no reset; each entry is written before a window reads it.
   always_ff @(posedge clk) begin
      if (transfer && state == ROW_EVEN) linebuf[col] <= pixel_d;
      if (transfer && state == ROW_ODD)  held         <= pixel_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         maxpool_en_maxfifo <= 1'b0;
         window_maxfifo     <= '0;
         out_row            <= '0;
         out_col            <= '0;
      end else begin
         maxpool_en_maxfifo <= emit;
         if (emit) begin
            window_maxfifo[0][0] <= linebuf[col - 1'b1];
            window_maxfifo[0][1] <= linebuf[col];
            window_maxfifo[1][0] <= held;
            window_maxfifo[1][1] <= pixel_d;
            out_row              <= OUT_ROW_W'(row >> 1);
            out_col              <= OUT_COL_W'(col >> 1);
         end
      end
   end

endmodule

// File: tb/tb_maxpool_window_ctrl.sv
// Randomized self-checking bench: a 4x4 and a 5x5 instance checked against a frame-level window model.
module tb_maxpool_window_ctrl;

   localparam int DW = 16;
   localparam int NU = 2;

   logic clk;
   logic rst;

   logic                    start       [NU];
   logic [DW-1:0]           pixel_in    [NU];
   logic                    pixel_valid [NU];
   logic                    pixel_ready [NU];
   logic                    strobe      [NU];
   logic [1:0][1:0][DW-1:0] window      [NU];
   logic [0:0]              out_row     [NU];
   logic [0:0]              out_col     [NU];
   logic                    busy        [NU];
   logic                    frame_done  [NU];

   logic [DW-1:0]           img      [25];
   logic [1:0][1:0][DW-1:0] last_win [NU];

   int n_checks;
   int n_pass;

   maxpool_window_ctrl #(
      .DATA_WIDTH(DW), .KERNEL_SIZE(2), .IMG_WIDTH(4), .IMG_HEIGHT(4)
   ) dut4 (
      .clk(clk), .rst(rst), .start(start[0]), .pixel_in(pixel_in[0]),
      .pixel_valid(pixel_valid[0]), .pixel_ready(pixel_ready[0]),
      .maxpool_en_maxfifo(strobe[0]), .window_maxfifo(window[0]),
      .out_row(out_row[0]), .out_col(out_col[0]), .busy(busy[0]),
      .frame_done(frame_done[0])
   );

   maxpool_window_ctrl #(
      .DATA_WIDTH(DW), .KERNEL_SIZE(2), .IMG_WIDTH(5), .IMG_HEIGHT(5)
   ) dut5 (
      .clk(clk), .rst(rst), .start(start[1]), .pixel_in(pixel_in[1]),
      .pixel_valid(pixel_valid[1]), .pixel_ready(pixel_ready[1]),
      .maxpool_en_maxfifo(strobe[1]), .window_maxfifo(window[1]),
      .out_row(out_row[1]), .out_col(out_col[1]), .busy(busy[1]),
      .frame_done(frame_done[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int img_w(input int u);
      return (u == 0) ? 4 : 5;
   endfunction

   function automatic int img_h(input int u);
      return (u == 0) ? 4 : 5;
   endfunction

   function automatic logic [DW-1:0] mp(input logic [DW-1:0] x);
`ifdef MAXPOOL_CTRL_RELU_EN
      return x[DW-1] ? '0 : x;
`else
      return x;
`endif
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic check_quiet(input int u, input string when);
      check($sformatf("u%0d %s ready", u, when), pixel_ready[u], 0);
      check($sformatf("u%0d %s busy", u, when), busy[u], 0);
      check($sformatf("u%0d %s frame_done", u, when), frame_done[u], 0);
      check($sformatf("u%0d %s strobe", u, when), strobe[u], 0);
   endtask

   // vmode: 0 valid always, 1 toggling, 2 random. abort_at >= 0 pulses rst once that many pixels are in.
   task automatic run_frame(input int u, input int vmode, input bit rnd, input int base,
                            input int abort_at, input bit start_noise);
      int w, h, n, idx, cycles, strobes, r, c;
      bit v, acc, exp_strobe;
      logic [1:0][1:0][DW-1:0] ew;
      w = img_w(u);
      h = img_h(u);
      n = w * h;
      for (int i = 0; i < n; i++) img[i] = rnd ? DW'($urandom) : DW'(base + i);
      @(negedge clk);
      check($sformatf("u%0d pre ready", u), pixel_ready[u], 0);
      check($sformatf("u%0d pre busy", u), busy[u], 0);
      start[u] = 1'b1;
      @(negedge clk);
      start[u] = 1'b0;
      check($sformatf("u%0d started busy", u), busy[u], 1);
      check($sformatf("u%0d started ready", u), pixel_ready[u], 1);
      idx     = 0;
      cycles  = 0;
      strobes = 0;
      while (idx < n) begin
         if (abort_at >= 0 && idx == abort_at) begin
            pixel_valid[u] = 1'b1;
            pixel_in[u]    = img[idx];
            rst            = 1'b1;
            @(negedge clk);
            rst            = 1'b0;
            pixel_valid[u] = 1'b0;
            for (int k = 0; k < NU; k++) last_win[k] = '0;
            check_quiet(u, "abort");
            check($sformatf("u%0d abort window", u), window[u], 0);
            @(negedge clk);
            check_quiet(u, "post_abort");
            return;
         end
         case (vmode)
            0:       v = 1'b1;
            1:       v = (cycles % 2 == 0);
            default: v = ($urandom_range(99) < 70);
         endcase
         pixel_valid[u] = v;
         pixel_in[u]    = v ? img[idx] : DW'($urandom);
         start[u]       = start_noise && ($urandom_range(3) == 0);
         acc            = v && pixel_ready[u];
         @(negedge clk);
         r          = idx / w;
         c          = idx % w;
         exp_strobe = acc && (r % 2 == 1) && (c % 2 == 1);
         check($sformatf("u%0d strobe@%0d", u, idx), strobe[u], exp_strobe);
         if (exp_strobe) begin
            ew[0][0]    = mp(img[(r - 1) * w + c - 1]);
            ew[0][1]    = mp(img[(r - 1) * w + c]);
            ew[1][0]    = mp(img[r * w + c - 1]);
            ew[1][1]    = mp(img[idx]);
            last_win[u] = ew;
            strobes++;
            check($sformatf("u%0d out_row@%0d", u, idx), out_row[u], r / 2);
            check($sformatf("u%0d out_col@%0d", u, idx), out_col[u], c / 2);
         end
         check($sformatf("u%0d window@%0d", u, idx), window[u], last_win[u]);
         if (acc) idx++;
         check($sformatf("u%0d frame_done@%0d", u, idx), frame_done[u], acc && idx == n);
         check($sformatf("u%0d ready@%0d", u, idx), pixel_ready[u], idx < n);
         check($sformatf("u%0d busy@%0d", u, idx), busy[u], idx < n);
         cycles++;
         if (cycles > 40 * n) begin
            check($sformatf("u%0d timeout pixels", u), idx, n);
            break;
         end
      end
      pixel_valid[u] = 1'b0;
      start[u]       = 1'b0;
      check($sformatf("u%0d strobe count", u), strobes, (h / 2) * (w / 2));
      @(negedge clk);
      check_quiet(u, "idle");
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b1;
      for (int k = 0; k < NU; k++) begin
         start[k]       = 1'b0;
         pixel_in[k]    = '0;
         pixel_valid[k] = 1'b0;
         last_win[k]    = '0;
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < NU; k++) begin
         check_quiet(k, "reset");
         check($sformatf("u%0d reset window", k), window[k], 0);
         check($sformatf("u%0d reset out_row", k), out_row[k], 0);
         check($sformatf("u%0d reset out_col", k), out_col[k], 0);
      end
      rst = 1'b0;

      run_frame(0, 0, 1'b0, 0, -1, 1'b0);     // 4x4 ramp, valid always high
      run_frame(0, 1, 1'b0, 0, -1, 1'b0);     // 4x4 ramp, valid toggling
      run_frame(1, 0, 1'b0, 0, -1, 1'b0);     // 5x5 ramp, odd edges dropped
      run_frame(0, 0, 1'b0, 0, 10, 1'b0);     // reset after pixel 9
      run_frame(0, 0, 1'b0, 100, -1, 1'b0);   // restart with 100..115
      run_frame(0, 0, 1'b0, 0, -1, 1'b1);     // start pulses mid-frame
      run_frame(1, 1, 1'b0, 0, -1, 1'b1);
      for (int t = 0; t < 8; t++) run_frame(t % 2, 2, 1'b1, 0, -1, 1'($urandom_range(1)));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end

endmodule
